// File: rtl/bus_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// bus_xfer_sequencer
//
// Purpose
//   Generates the datapath control strobes for the three basic bus operations:
//   a two-byte instruction fetch (M -> IR0, then M -> IR1), a register-to-
//   register move (MOV) and an immediate load (MVI, source IMM_ID, where the
//   data bus is driven externally). A one-cycle start request is turned into
//   a timed sequence of output enables, write enables, address-bus selects and
//   a PC increment. This block is the only driver of those strobes.
//
// Ports
//   clk          in   1        system clock, all state on the rising edge
//   reset        in   1        asynchronous, active-high; clears all state
//   start_fetch  in   1        request a 2-byte instruction fetch
//   start_mov    in   1        request one transfer src_id -> dst_id
//   src_id       in   ID_W     transfer source, sampled with start_mov
//   dst_id       in   ID_W     transfer destination, sampled with start_mov
//   oe_vec       out  NUM_SRC  one-hot data-bus output enables (bit = src ID)
//   we_vec       out  NUM_DST  one-hot data-bus write enables (bit = dst ID)
//   oe_pc        out  1        address bus driven from PC
//   oe_ar        out  1        address bus driven from AR
//   pc_inr       out  1        PC increment strobe
//   busy         out  1        high in every non-IDLE state
//   done         out  1        pulse in the final active cycle of an operation
//   err          out  1        pulse one cycle after a rejected MOV request
//
// All outputs are decoded only from registered state (state, latched IDs and
// the error flag), so there is no combinational path from inputs to outputs,
// and an asynchronous reset forces every output low immediately.
// -----------------------------------------------------------------------------
module bus_xfer_sequencer #(
  parameter int ID_W    = 5,
  parameter int NUM_SRC = 15,
  parameter int NUM_DST = 13,
  parameter int IMM_ID  = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_fetch,
  input  logic               start_mov,
  input  logic [ID_W-1:0]    src_id,
  input  logic [ID_W-1:0]    dst_id,
  output logic [NUM_SRC-1:0] oe_vec,
  output logic [NUM_DST-1:0] we_vec,
  output logic               oe_pc,
  output logic               oe_ar,
  output logic               pc_inr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Source / destination ID of the memory (M); it also selects AR as the
  // address source during a move.
  localparam logic [ID_W-1:0] ID_M   = ID_W'(4);
  localparam logic [ID_W-1:0] ID_IMM = ID_W'(IMM_ID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_F3,
    S_MV
  } state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] src_q, dst_q;
  logic            err_q;

  logic            accept;    // a new request may be taken at this edge
  logic            mov_legal;
  logic            ld_ids;    // latch src/dst for an accepted move
  logic            err_set;   // reject an illegal move

  // A legal source is a real register (0..NUM_SRC-1) or the immediate marker;
  // a legal destination is a writable register; a register never moves to
  // itself.
  assign mov_legal = ((src_id < ID_W'(NUM_SRC)) || (src_id == ID_IMM)) &&
                     (dst_id < ID_W'(NUM_DST)) &&
                     (src_id != dst_id);

  // Requests are taken in IDLE and also in the done cycle of an operation,
  // which lets operations run back to back without an idle gap.
  assign accept  = (state == S_IDLE) || (state == S_F3) || (state == S_MV);
  assign ld_ids  = accept && !start_fetch && start_mov && mov_legal;
  assign err_set = accept && !start_fetch && start_mov && !mov_legal;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  // NOTE: the latched IDs are reset as well, so the output decode never sees
  // stale IDs after reset, even though it only uses them in S_MV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_set;
      if (ld_ids) begin
        src_q <= src_id;
        dst_q <= dst_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_F0:    state_n = S_F1;
      S_F1:    state_n = S_F2;
      S_F2:    state_n = S_F3;
      default: state_n = S_IDLE;   // S_IDLE, S_F3, S_MV
    endcase
    // Fetch has priority; a simultaneous move request is dropped silently.
    if (accept) begin
      if (start_fetch) begin
        state_n = S_F0;
      end else if (start_mov && mov_legal) begin
        state_n = S_MV;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    oe_vec = '0;
    we_vec = '0;
    oe_pc  = 1'b0;
    oe_ar  = 1'b0;
    pc_inr = 1'b0;
    done   = 1'b0;
    busy   = (state != S_IDLE);
    err    = err_q;
    case (state)
      S_F0, S_F2: begin
        oe_pc     = 1'b1;
        oe_vec[4] = 1'b1;
      end
      S_F1: begin
        oe_pc     = 1'b1;
        oe_vec[4] = 1'b1;
        we_vec[0] = 1'b1;
        pc_inr    = 1'b1;
      end
      S_F3: begin
        oe_pc     = 1'b1;
        oe_vec[4] = 1'b1;
        we_vec[1] = 1'b1;
        pc_inr    = 1'b1;
        done      = 1'b1;
      end
      S_MV: begin
        // The immediate source is driven onto the data bus externally, so
        // no output enable is raised for it.
        if (src_q != ID_IMM) begin
          oe_vec = NUM_SRC'(1) << src_q;
        end
        we_vec = NUM_DST'(1) << dst_q;
        oe_ar  = (src_q == ID_M) || (dst_q == ID_M);
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_sequencer
//
// Scoreboard bench: each stimulus pushes the expected per-cycle output words
// (tagged with the cycle they must appear in) into a queue. A monitor on the
// falling edge pops and compares whenever the DUT shows activity, and checks
// that the outputs are quiet in every cycle without an expectation.
// -----------------------------------------------------------------------------
module tb_bus_xfer_sequencer;

  localparam int ID_W    = 5;
  localparam int NUM_SRC = 15;
  localparam int NUM_DST = 13;
  localparam int IMM_ID  = 31;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_fetch;
  logic               start_mov;
  logic [ID_W-1:0]    src_id;
  logic [ID_W-1:0]    dst_id;
  logic [NUM_SRC-1:0] oe_vec;
  logic [NUM_DST-1:0] we_vec;
  logic               oe_pc;
  logic               oe_ar;
  logic               pc_inr;
  logic               busy;
  logic               done;
  logic               err;

  bus_xfer_sequencer #(
    .ID_W    (ID_W),
    .NUM_SRC (NUM_SRC),
    .NUM_DST (NUM_DST),
    .IMM_ID  (IMM_ID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_fetch (start_fetch),
    .start_mov   (start_mov),
    .src_id      (src_id),
    .dst_id      (dst_id),
    .oe_vec      (oe_vec),
    .we_vec      (we_vec),
    .oe_pc       (oe_pc),
    .oe_ar       (oe_ar),
    .pc_inr      (pc_inr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter, advanced on every rising edge.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Packed output word: {oe_vec, we_vec, oe_pc, oe_ar, pc_inr, busy, done, err}
  typedef logic [33:0] word_t;
  typedef struct {
    int    cyc;
    word_t v;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  word_t dut_word;
  assign dut_word = {oe_vec, we_vec, oe_pc, oe_ar, pc_inr, busy, done, err};

  function automatic word_t mk(logic [14:0] oe, logic [12:0] we, logic opc,
                               logic oar, logic inr, logic bsy, logic dn,
                               logic er);
    return {oe, we, opc, oar, inr, bsy, dn, er};
  endfunction

  task automatic check(string name, int at, word_t act, word_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, at, act, exp);
    end
  endtask

  // --- expectation builders ---------------------------------------------------
  task automatic push_fetch(int base);
    q.push_back('{base,     mk(15'h0010, 13'h0000, 1, 0, 0, 1, 0, 0)});
    q.push_back('{base + 1, mk(15'h0010, 13'h0001, 1, 0, 1, 1, 0, 0)});
    q.push_back('{base + 2, mk(15'h0010, 13'h0000, 1, 0, 0, 1, 0, 0)});
    q.push_back('{base + 3, mk(15'h0010, 13'h0002, 1, 0, 1, 1, 1, 0)});
  endtask

  task automatic push_mv(int base, logic [14:0] oe, logic [12:0] we, logic oar);
    q.push_back('{base, mk(oe, we, 0, oar, 0, 1, 1, 0)});
  endtask

  task automatic push_err(int base);
    q.push_back('{base, mk(15'h0, 13'h0, 0, 0, 0, 0, 0, 1)});
  endtask

  // --- monitor ----------------------------------------------------------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("out", cyc, dut_word, e.v);
      end else begin
        check("idle", cyc, dut_word, '0);
      end
    end
  end

  // --- stimulus helpers ---------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic f, logic m, logic [4:0] s, logic [4:0] d);
    start_fetch = f;
    start_mov   = m;
    src_id      = s;
    dst_id      = d;
  endtask

  task automatic idle(int n);
    drive(0, 0, 5'd0, 5'd0);
    repeat (n) step();
  endtask

  // One-cycle move request; expectation is pushed by the caller.
  task automatic mov_pulse(logic [4:0] s, logic [4:0] d);
    drive(0, 1, s, d);
    step();
    drive(0, 0, 5'd0, 5'd0);
  endtask

  int b;

  initial begin
    reset = 1'b1;
    drive(0, 0, 5'd0, 5'd0);
    #1;
    check("reset", cyc, dut_word, '0);
    repeat (2) step();
    reset = 1'b0;
    idle(2);

    // 1: plain fetch
    b = cyc;
    drive(1, 0, 5'd0, 5'd0);
    push_fetch(b + 1);
    step();
    idle(6);

    // 2: R0 -> A
    b = cyc;
    push_mv(b + 1, 15'h0020, 13'h0004, 0);
    mov_pulse(5'd5, 5'd2);
    idle(3);

    // 3: immediate -> R1, then M-involved move raises oe_ar
    b = cyc;
    push_mv(b + 1, 15'h0000, 13'h0040, 0);
    mov_pulse(5'd31, 5'd6);
    idle(2);
    b = cyc;
    push_mv(b + 1, 15'h0010, 13'h0008, 1);
    mov_pulse(5'd4, 5'd3);
    idle(2);
    b = cyc;
    push_mv(b + 1, 15'h0004, 13'h0010, 1);
    mov_pulse(5'd2, 5'd4);
    idle(2);

    // 4: illegal requests
    b = cyc;
    push_err(b + 1);
    mov_pulse(5'd13, 5'd13);
    idle(2);
    b = cyc;
    push_err(b + 1);
    mov_pulse(5'd2, 5'd14);
    idle(2);
    b = cyc;
    push_err(b + 1);
    mov_pulse(5'd20, 5'd0);
    idle(2);

    // 5: fetch beats mov; mov during F1 ignored; mov in F3 chains
    b = cyc;
    drive(1, 1, 5'd5, 5'd2);
    push_fetch(b + 1);
    step();                       // F0
    drive(0, 0, 5'd0, 5'd0);
    step();                       // F1
    drive(0, 1, 5'd5, 5'd2);
    step();                       // F2
    drive(0, 0, 5'd0, 5'd0);
    step();                       // F3
    drive(0, 1, 5'd9, 5'd1);
    push_mv(b + 5, 15'h0200, 13'h0002, 0);
    step();                       // MV
    idle(4);

    // 6: async reset during F2
    b = cyc;
    drive(1, 0, 5'd0, 5'd0);
    q.push_back('{b + 1, mk(15'h0010, 13'h0000, 1, 0, 0, 1, 0, 0)});
    q.push_back('{b + 2, mk(15'h0010, 13'h0001, 1, 0, 1, 1, 0, 0)});
    step();                       // F0
    drive(0, 0, 5'd0, 5'd0);
    step();                       // F1
    step();                       // F2 now showing
    reset = 1'b1;
    #1;
    check("async_rst", cyc, dut_word, '0);
    q.delete();
    repeat (2) step();
    reset = 1'b0;
    idle(3);
    b = cyc;
    push_mv(b + 1, 15'h0001, 13'h0020, 0);
    mov_pulse(5'd0, 5'd5);
    idle(4);

    check("drain", cyc, word_t'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
